// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only peripheral: synchronizes sclk/copi/ncs into clk, assembles
// 16-bit frames {wr, addr[6:0], data[7:0]} and commits writes into five 8-bit registers.
//   state | meaning
//   IDLE  | waiting for a chip-select falling edge
//   SHIFT | collecting frame bits on sclk rising edges
//   FULL  | 16 bits held; extra sclk edges ignored until chip-select rises
module spi_peripheral #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);
    localparam int unsigned NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

    logic [NS-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q, vld_q;
    logic          sclk_prev_q, ncs_prev_q, armed_q;
    logic          sclk_s, copi_s, ncs_s;
    logic          sclk_rise, ncs_rise, ncs_fall;

    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [15:0]   shift_q, shift_d;
    logic [7:0]    regs_q [5];
    logic [7:0]    regs_d [5];
    logic          wr_strobe_q, wr_strobe_d;
    logic          frame_err_q, frame_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            vld_q       <= '0;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[NS-2:0], sclk};
            copi_sync_q <= {copi_sync_q[NS-2:0], copi};
            ncs_sync_q  <= {ncs_sync_q[NS-2:0], ncs};
            vld_q       <= {vld_q[NS-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            ncs_prev_q  <= ncs_s;
            // Only accept a frame start once chip-select has truly been seen high after reset
            armed_q     <= armed_q | (vld_q[NS-1] & ncs_s);
        end
    end

    assign sclk_s    = sclk_sync_q[NS-1];
    assign copi_s    = copi_sync_q[NS-1];
    assign ncs_s     = ncs_sync_q[NS-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign ncs_fall  = armed_q & ncs_prev_q & ~ncs_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < 5; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
            for (int i = 0; i < 5; i++) regs_q[i] <= regs_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ncs_fall) state_d = SHIFT;
            SHIFT: begin
                if (ncs_rise)
                    state_d = IDLE;
                else if (sclk_rise && !ncs_s && cnt_q == 5'd15)
                    state_d = FULL;
            end
            FULL:    if (ncs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        wr_strobe_d = 1'b0;
        frame_err_d = 1'b0;
        for (int i = 0; i < 5; i++) regs_d[i] = regs_q[i];
        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            SHIFT: begin
                // chip-select edge wins over a coincident sclk edge
                if (ncs_rise) begin
                    frame_err_d = 1'b1;
                end else if (sclk_rise && !ncs_s) begin
                    shift_d = {shift_q[14:0], copi_s};
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            FULL: begin
                if (ncs_rise && shift_q[15] && shift_q[14:8] <= MAX_ADDR) begin
                    wr_strobe_d = 1'b1;
                    for (int i = 0; i < 5; i++)
                        if (shift_q[14:8] == 7'(i)) regs_d[i] = shift_q[7:0];
                end
            end
            default: ;
        endcase
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign wr_strobe       = wr_strobe_q;
    assign frame_err       = frame_err_q;
endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: directed and random SPI frames, expected
// pulses and register images queued at chip-select release, checked by a monitor.
module tb_spi_peripheral;
    localparam int NS   = 2;
    localparam int HALF = NS + 2;
    localparam logic [6:0] MAX_ADDR = 7'h04;

    logic clk = 1'b0;
    logic rst, sclk, copi, ncs;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic wr_strobe, frame_err;

    spi_peripheral #(.SYNC_STAGES(NS), .MAX_ADDR(MAX_ADDR)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [39:0] regs;
        int          cyc;
    } ev_t;

    ev_t         q[$];
    logic [7:0]  m_regs [5];
    logic [39:0] exp_now;
    int          cyc = 0;
    logic        rst_q = 1'b1;
    int          n_vec = 0;
    int          n_fail = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [39:0] pack_model();
        return {m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    always @(negedge clk) begin
        logic [39:0] dut_regs;
        ev_t e;
        dut_regs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
        if (rst_q) begin
            exp_now = '0;
            chk("reset_regs", 64'(dut_regs), 64'(0));
            chk("reset_pulses", 64'({wr_strobe, frame_err}), 64'(0));
        end else if (wr_strobe || frame_err) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", 64'({wr_strobe, frame_err}), 64'(0));
            end else begin
                e = q.pop_front();
                chk("pulse_kind", 64'({wr_strobe, frame_err}), e.err ? 64'(1) : 64'(2));
                chk("commit_regs", 64'(dut_regs), 64'(e.regs));
                chk("latency_cycle", 64'(cyc), 64'(e.cyc));
                exp_now = e.regs;
            end
        end else begin
            chk("regs_hold", 64'(dut_regs), 64'(exp_now));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            tick(HALF);
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
        end
    endtask

    // bits holds the n-bit sequence MSB first; only the first 16 form the frame
    task automatic run_frame(input logic [31:0] bits, input int n);
        logic [15:0] w;
        ev_t e;
        bit has;
        ncs = 1'b0;
        tick(HALF);
        send_bits(bits, n);
        tick(HALF);
        has = 0;
        e.err = 0;
        if (n < 16) begin
            has = 1;
            e.err = 1;
        end else begin
            w = bits[n-1 -: 16];
            if (w[15] && w[14:8] <= MAX_ADDR) begin
                has = 1;
                if (w[14:8] < 7'd5) m_regs[int'(w[14:8])] = w[7:0];
            end
        end
        e.regs = pack_model();
        e.cyc  = cyc + NS + 1;
        if (has) q.push_back(e);
        ncs = 1'b1;
        tick(2 * HALF);
    endtask

    initial begin
        int n, r;
        logic [15:0] w;
        logic [31:0] bits;
        rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        for (int i = 0; i < 5; i++) m_regs[i] = '0;
        tick(5);
        rst = 1'b0;
        tick(2 * HALF);

        run_frame(32'h80F0, 16);
        run_frame(32'h84C8, 16);
        run_frame(32'h04FF, 16);
        run_frame(32'h8A55, 16);
        run_frame(32'h8301 >> 7, 9);
        run_frame(32'h8301, 16);
        run_frame((32'h82AA << 4) | 32'h9, 20);

        // reset mid-frame with chip-select held low through the rest of the frame
        ncs = 1'b0;
        tick(HALF);
        send_bits(32'h81, 8);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) m_regs[i] = '0;
        tick(3);
        rst = 1'b0;
        send_bits(32'hFF, 8);
        tick(HALF);
        ncs = 1'b1;
        tick(2 * HALF);
        run_frame(32'h81FF, 16);

        for (int k = 0; k < 40; k++) begin
            w = {($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 7'($urandom_range(0, 11)), 8'($urandom)};
            r = $urandom_range(0, 9);
            if (r < 6)      n = 16;
            else if (r < 8) n = $urandom_range(1, 15);
            else            n = $urandom_range(17, 20);
            if (n >= 16)
                bits = (32'(w) << (n - 16)) | (32'($urandom) & ((32'd1 << (n - 16)) - 32'd1));
            else
                bits = 32'(w >> (16 - n));
            run_frame(bits, n);
        end

        for (int i = 0; i < 30 && q.size() != 0; i++) tick(1);
        chk("queue_drained", 64'(q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
